cmp_unit_seq: RTL and testbench



---
 rtl/cmp_unit_seq.sv | 157 +++++++++++++++
 tb/tb_cmp_unit_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_unit_seq.sv
// Multi-cycle RV32 branch comparator: subtracts a - b CHUNK bits per cycle, LSB chunk first.
// Optional macro CMP_EARLY_EXIT_EN: EQ/NE finish on the first mismatching chunk.
module cmp_unit_seq #(
    parameter int unsigned N     = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [2:0]   i_funct,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         o_result,
    output logic         o_eq,
    output logic         o_lt,
    output logic         o_ltu,
    output logic         o_illegal
);

    localparam int unsigned NCHUNK = N / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       a_q, b_q;
    logic [2:0]         funct_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic               eq_acc_q;

    logic               accept, finish, last, early;
    logic [CHUNK-1:0]   a_chunk, b_chunk;
    logic [CHUNK:0]     sum;
    logic               chunk_eq, eq_next, msb_cin, cout;
    logic               eq_op, illegal_op;
    logic               f_eq, f_lt, f_ltu, f_result;

    assign i_ready = (state_q == IDLE) && !rst;

    // Operand registers shift right each BUSY cycle, so the live chunk is always at the bottom
    assign a_chunk  = a_q[CHUNK-1:0];
    assign b_chunk  = b_q[CHUNK-1:0];
    assign sum      = {1'b0, a_chunk} + {1'b0, ~b_chunk} + (CHUNK+1)'(carry_q);
    assign cout     = sum[CHUNK];
    assign msb_cin  = a_chunk[CHUNK-1] ^ ~b_chunk[CHUNK-1] ^ sum[CHUNK-1];
    assign chunk_eq = (a_chunk == b_chunk);
    assign eq_next  = eq_acc_q & chunk_eq;
    assign last     = (idx_q == IDX_W'(NCHUNK - 1));

    assign eq_op      = (funct_q[2:1] == 2'b00);
    assign illegal_op = (funct_q[2:1] == 2'b01);

`ifdef CMP_EARLY_EXIT_EN
    assign early = eq_op && !chunk_eq;
`else
    assign early = 1'b0;
`endif

    // Final flags, valid in the cycle that finishes the subtraction
    assign f_eq  = eq_next;
    assign f_lt  = early ? 1'b0 : (sum[CHUNK-1] ^ msb_cin ^ cout);
    assign f_ltu = early ? 1'b0 : ~cout;

    always_comb begin
        f_result = 1'b0;
        case (funct_q)
            3'b000:  f_result = f_eq;
            3'b001:  f_result = ~f_eq;
            3'b100:  f_result = f_lt;
            3'b101:  f_result = ~f_lt;
            3'b110:  f_result = f_ltu;
            3'b111:  f_result = ~f_ltu;
            default: f_result = 1'b0;
        endcase
    end

    // Next-state and control strobes
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid && i_ready) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last || early) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (o_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            funct_q   <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            eq_acc_q  <= 1'b0;
            o_valid   <= 1'b0;
            o_result  <= 1'b0;
            o_eq      <= 1'b0;
            o_lt      <= 1'b0;
            o_ltu     <= 1'b0;
            o_illegal <= 1'b0;
        end else begin
            if (accept) begin
                a_q      <= i_a;
                b_q      <= i_b;
                funct_q  <= i_funct;
                carry_q  <= 1'b1;
                idx_q    <= '0;
                eq_acc_q <= 1'b1;
            end
            if (state_q == BUSY) begin
                a_q      <= a_q >> CHUNK;
                b_q      <= b_q >> CHUNK;
                carry_q  <= cout;
                eq_acc_q <= eq_next;
                if (!last) idx_q <= idx_q + IDX_W'(1);
            end
            if (finish) begin
                o_valid   <= 1'b1;
                o_eq      <= f_eq;
                o_lt      <= f_lt;
                o_ltu     <= f_ltu;
                o_illegal <= illegal_op;
                o_result  <= illegal_op ? 1'b0 : f_result;
            end
            if (state_q == DONE && o_ready) o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmp_unit_seq.sv
// Scoreboard bench for cmp_unit_seq: driver pushes model results, negedge monitor pops and compares.
module tb_cmp_unit_seq;

    localparam int N      = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = N / CHUNK;

    logic          clk, rst;
    logic          i_valid, i_ready;
    logic [N-1:0]  i_a, i_b;
    logic [2:0]    i_funct;
    logic          o_valid, o_ready;
    logic          o_result, o_eq, o_lt, o_ltu, o_illegal;

    cmp_unit_seq #(.N(N), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready),
        .i_a(i_a), .i_b(i_b), .i_funct(i_funct),
        .o_valid(o_valid), .o_ready(o_ready),
        .o_result(o_result), .o_eq(o_eq), .o_lt(o_lt), .o_ltu(o_ltu),
        .o_illegal(o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic res, eq, lt, ltu, ill;
        int   lat;
        int   acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   hold_bp = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer comparisons on the whole operands
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        exp_t e;
        e.eq  = (a == b);
        e.lt  = ($signed(a) < $signed(b));
        e.ltu = (a < b);
        e.ill = (f == 3'b010) || (f == 3'b011);
        e.lat = NCHUNK;
        e.acc = 0;
`ifdef CMP_EARLY_EXIT_EN
        if ((f == 3'b000 || f == 3'b001) && a != b) begin
            e.lt  = 1'b0;
            e.ltu = 1'b0;
            for (int k = NCHUNK - 1; k >= 0; k--)
                if (a[k*CHUNK +: CHUNK] != b[k*CHUNK +: CHUNK]) e.lat = k + 1;
        end
`endif
        case (f)
            3'b000:  e.res = e.eq;
            3'b001:  e.res = !e.eq;
            3'b100:  e.res = e.lt;
            3'b101:  e.res = !e.lt;
            3'b110:  e.res = e.ltu;
            3'b111:  e.res = !e.ltu;
            default: e.res = 1'b0;
        endcase
        return e;
    endfunction

    // Monitor
    exp_t cur;
    bit   seen = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (o_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got o_valid=1 expected no result (cycle %0d)", cyc);
                end else begin
                    cur = sb.pop_front();
                    chk("result",  32'(o_result),  32'(cur.res));
                    chk("eq",      32'(o_eq),      32'(cur.eq));
                    chk("lt",      32'(o_lt),      32'(cur.lt));
                    chk("ltu",     32'(o_ltu),     32'(cur.ltu));
                    chk("illegal", 32'(o_illegal), 32'(cur.ill));
                    chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                end
            end else begin
                chk("hold_result", 32'(o_result), 32'(cur.res));
            end
        end else begin
            seen = 1'b0;
        end
    end

    // Random consumer backpressure
    initial begin
        o_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!hold_bp) o_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                         input bit push);
        exp_t e;
        int   t = 0;
        @(negedge clk);
        while (!i_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!i_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got i_ready=0 expected 1 within 200 cycles");
            return;
        end
        i_a     = a;
        i_b     = b;
        i_funct = f;
        i_valid = 1'b1;
        if (push) begin
            e     = model(a, b, f);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_a     = $urandom;
        i_b     = $urandom;
        i_funct = 3'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || o_valid) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (sb.size() != 0 || o_valid) begin
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
        end
    endtask

    logic [31:0] corners [6] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                                 32'h7FFF_FFFF, 32'h0000_0001, 32'h1234_5678};

    initial begin
        int t;
        logic [31:0] ra, rb;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_funct = '0;

        // Reset behaviour
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            chk("rst_i_ready", 32'(i_ready), 32'd0);
            chk("rst_outputs", {27'd0, o_valid, o_result, o_eq, o_lt, o_ltu} | 32'(o_illegal), 32'd0);
        end
        rst = 1'b0;
        #1 chk("post_rst_i_ready", 32'(i_ready), 32'd1);
        hold_bp = 1'b0;

        // Directed corners
        issue(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 1);
        issue(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 1);
        issue(32'h8000_0000, 32'h8000_0000, 3'b000, 1);
        issue(32'h8000_0000, 32'h8000_0000, 3'b100, 1);
        issue(32'h0000_0000, 32'hFFFF_FFFF, 3'b100, 1);
        issue(32'h0000_0000, 32'hFFFF_FFFF, 3'b110, 1);
        issue(32'h0000_00FF, 32'h0000_0000, 3'b001, 1);
        issue(32'h1234_0000, 32'h0000_5678, 3'b010, 1);
        issue(32'h0000_0005, 32'h0000_0005, 3'b011, 1);
        issue(32'h0100_0000, 32'h0000_0000, 3'b000, 1);
        wait_idle();

        // Backpressure: result must hold while o_ready is low
        hold_bp = 1'b1;
        o_ready = 1'b0;
        issue(32'h1234_5678, 32'h1234_5678, 3'b000, 1);
        t = 0;
        while (!o_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid",   32'(o_valid),  32'd1);
            chk("bp_result",  32'(o_result), 32'd1);
            chk("bp_i_ready", 32'(i_ready),  32'd0);
        end
        o_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid",   32'(o_valid), 32'd0);
        chk("bp_release_i_ready", 32'(i_ready), 32'd1);
        hold_bp = 1'b0;

        // Abort in the second BUSY cycle
        issue(32'h0000_0001, 32'h0000_0002, 3'b100, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid",   32'(o_valid), 32'd0);
        chk("abort_i_ready", 32'(i_ready), 32'd0);
        rst = 1'b0;
        #1 chk("abort_idle", 32'(i_ready), 32'd1);
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(o_valid), 32'd0);
        end

        // Randomized operations
        repeat (150) begin
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom; rb = ra; end
                2: begin ra = corners[$urandom_range(0, 5)]; rb = corners[$urandom_range(0, 5)]; end
                default: begin
                    ra = $urandom;
                    rb = ra ^ (32'($urandom_range(1, 255)) << (CHUNK * $urandom_range(0, NCHUNK - 1)));
                end
            endcase
            issue(ra, rb, 3'($urandom_range(0, 7)), 1);
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
